// File: rtl/oflow_mem_history_pkg.sv
// Shared defaults, FSM state type and width helpers for the frame-history buffer.
// No logic: parameters and constant functions only.
// Imported by the buffer top level and its storage bank.
package oflow_mem_history_pkg;

  localparam int DEF_DATA_W      = 64;
  localparam int DEF_LANES       = 2;
  localparam int DEF_MAX_BBOX    = 32;
  localparam int DEF_HIST_DEPTH  = 5;
  localparam int DEF_FRAME_NUM_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } hist_state_e;

  // Bits needed to hold a bbox count 0..max_bbox
  function automatic int bbox_w(input int max_bbox);
    return $clog2(max_bbox + 1);
  endfunction

  // Bits needed to hold a frame count 0..depth
  function automatic int hist_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Lines one frame occupies in the bank
  function automatic int lines_per_frame(input int max_bbox, input int lanes);
    return (max_bbox + lanes - 1) / lanes;
  endfunction

  // Bank line address width
  function automatic int addr_w(input int depth, input int max_bbox, input int lanes);
    int n;
    n = depth * lines_per_frame(max_bbox, lanes);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_BBOX_W = bbox_w(DEF_MAX_BBOX);
  localparam int DEF_HIST_W = hist_w(DEF_HIST_DEPTH);
  localparam int DEF_LPF    = lines_per_frame(DEF_MAX_BBOX, DEF_LANES);
  localparam int DEF_ADDR_W = addr_w(DEF_HIST_DEPTH, DEF_MAX_BBOX, DEF_LANES);

endpackage

// File: rtl/oflow_mem_history_bank.sv
// Frame-history line store: one write port with per-lane enables, one read port.
// Latency: read data is registered, valid the cycle after i_rd_en.
// Backpressure: none; the caller only issues reads it can absorb.
module oflow_mem_history_bank
  import oflow_mem_history_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LANES  = DEF_LANES,
  parameter int DEPTH  = DEF_HIST_DEPTH * DEF_LPF,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [LANES-1:0]        i_wr_en,
  input  logic [ADDR_W-1:0]       i_wr_addr,
  input  logic [LANES*DATA_W-1:0] i_wr_dat,
  input  logic                    i_rd_en,
  input  logic [ADDR_W-1:0]       i_rd_addr,
  output logic [LANES*DATA_W-1:0] o_rd_dat
);

  logic [LANES*DATA_W-1:0] r_mem [DEPTH];
  logic [LANES*DATA_W-1:0] r_rd_dat;

  // Array write, lane by lane; no reset so it maps onto plain RAM
  always_ff @(posedge i_clk) begin
    for (int l = 0; l < LANES; l++) begin
      if (i_wr_en[l]) r_mem[i_wr_addr][l*DATA_W +: DATA_W] <= i_wr_dat[l*DATA_W +: DATA_W];
    end
  end

  // Registered read port; cleared on reset so the output starts at zero
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)        r_rd_dat <= '0;
    else if (i_rd_en) r_rd_dat <= r_mem[i_rd_addr];
  end

  assign o_rd_dat = r_rd_dat;

endmodule

// File: rtl/oflow_mem_history_buffer.sv
// Circular store of the last HIST_DEPTH frames' bbox records, replayed newest first.
// Latency: first read line 2 cycles after start_read, then 1 cycle per accepted line.
// Backpressure: wr_ready only in WRITE; a read line is held until read_new_line.
module oflow_mem_history_buffer
  import oflow_mem_history_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int LANES       = DEF_LANES,
  parameter int MAX_BBOX    = DEF_MAX_BBOX,
  parameter int HIST_DEPTH  = DEF_HIST_DEPTH,
  parameter int FRAME_NUM_W = DEF_FRAME_NUM_W
) (
  input  logic                              clk,
  input  logic                              reset_N,
  input  logic                              start_write,
  input  logic                              start_read,
  input  logic [FRAME_NUM_W-1:0]            frame_num,
  input  logic [bbox_w(MAX_BBOX)-1:0]       num_of_bbox_in_frame,
  input  logic [hist_w(HIST_DEPTH)-1:0]     num_of_history_frames,
  input  logic                              wr_valid,
  output logic                              wr_ready,
  input  logic [LANES*DATA_W-1:0]           wr_data,
  input  logic                              read_new_line,
  output logic                              rd_valid,
  output logic [LANES*DATA_W-1:0]           rd_data,
  output logic [LANES-1:0]                  rd_lane_valid,
  output logic [FRAME_NUM_W-1:0]            rd_frame_num,
  output logic [hist_w(HIST_DEPTH)-1:0]     rd_hist_idx,
  output logic                              done_write,
  output logic                              done_read,
  output logic [hist_w(HIST_DEPTH)-1:0]     counter_of_history_frame_to_interface
);

  localparam int BBOX_W = bbox_w(MAX_BBOX);
  localparam int HIST_W = hist_w(HIST_DEPTH);
  localparam int LPF    = lines_per_frame(MAX_BBOX, LANES);
  localparam int ADDR_W = addr_w(HIST_DEPTH, MAX_BBOX, LANES);
  localparam int LINE_W = $clog2(LPF + 1);
  localparam int SLOT_W = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;

  // Slot holding the frame k places back from the newest completed one
  function automatic logic [SLOT_W-1:0] slot_of(input logic [SLOT_W-1:0] wr_slot, input int k);
    int s;
    s = int'(wr_slot) + HIST_DEPTH - 1 - k;
    if (s >= HIST_DEPTH) s = s - HIST_DEPTH;
    return SLOT_W'(s);
  endfunction

  function automatic int lines_of(input logic [BBOX_W-1:0] n);
    return (int'(n) + LANES - 1) / LANES;
  endfunction

  hist_state_e             r_state, w_state_nxt;
  logic [SLOT_W-1:0]       r_wr_slot;
  logic [HIST_W-1:0]       r_count;
  logic [FRAME_NUM_W-1:0]  r_wr_fn;
  logic [BBOX_W-1:0]       r_wr_n;
  logic [LINE_W-1:0]       r_beat;
  logic [BBOX_W-1:0]       r_meta_n  [HIST_DEPTH];
  logic [FRAME_NUM_W-1:0]  r_meta_fn [HIST_DEPTH];
  logic [HIST_W-1:0]       r_frames, r_iss_hist;
  logic [LINE_W-1:0]       r_iss_line;
  logic                    r_iss_more;
  logic                    r_rd_vld, r_done_wr, r_done_rd;
  logic [LANES-1:0]        r_lane_vld;
  logic [FRAME_NUM_W-1:0]  r_rd_fn;
  logic [HIST_W-1:0]       r_rd_hist;

  logic [BBOX_W-1:0]       w_n_clamp, w_commit_n, w_iss_n;
  logic [FRAME_NUM_W-1:0]  w_commit_fn;
  logic [HIST_W-1:0]       w_f, w_found_k;
  logic [SLOT_W-1:0]       w_iss_slot;
  logic                    w_found, w_wr_acc, w_wr_commit, w_rd_setup, w_rd_issue, w_rd_done;
  logic [LANES-1:0]        w_bank_we, w_rd_mask;
  logic [ADDR_W-1:0]       w_wr_addr, w_rd_addr;
  int                      w_srch_base, w_srch_lim;

  assign w_n_clamp   = (int'(num_of_bbox_in_frame) > MAX_BBOX) ? BBOX_W'(MAX_BBOX) : num_of_bbox_in_frame;
  assign w_f         = (num_of_history_frames < r_count) ? num_of_history_frames : r_count;
  assign w_commit_n  = (r_state == IDLE) ? '0 : r_wr_n;
  assign w_commit_fn = (r_state == IDLE) ? frame_num : r_wr_fn;
  assign w_iss_slot  = slot_of(r_wr_slot, int'(r_iss_hist));
  assign w_iss_n     = r_meta_n[w_iss_slot];
  assign w_wr_addr   = ADDR_W'(int'(r_wr_slot) * LPF + int'(r_beat));
  assign w_rd_addr   = ADDR_W'(int'(w_iss_slot) * LPF + int'(r_iss_line));

  // Search window: from the start of history when launching a read, past the current frame while reading
  always_comb begin
    w_srch_base = 0;
    w_srch_lim  = int'(w_f);
    if (r_state == READ) begin
      w_srch_base = int'(r_iss_hist) + 1;
      w_srch_lim  = int'(r_frames);
    end
  end

  // First non-empty frame inside the search window; empty frames produce no lines
  always_comb begin
    w_found   = 1'b0;
    w_found_k = '0;
    for (int j = HIST_DEPTH - 1; j >= 0; j--) begin
      if (j >= w_srch_base && j < w_srch_lim && r_meta_n[slot_of(r_wr_slot, j)] != '0) begin
        w_found   = 1'b1;
        w_found_k = HIST_W'(j);
      end
    end
  end

  // Lane enables for the write beat and lane-valid mask for the line being fetched
  always_comb begin
    w_bank_we = '0;
    w_rd_mask = '0;
    for (int l = 0; l < LANES; l++) begin
      w_bank_we[l] = w_wr_acc && ((int'(r_beat) * LANES + l) < int'(r_wr_n));
      w_rd_mask[l] = (int'(r_iss_line) * LANES + l) < int'(w_iss_n);
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset_N) begin
    if (reset_N) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // FSM next state and control strobes; write wins over read in IDLE
  always_comb begin
    w_state_nxt = r_state;
    w_wr_acc    = 1'b0;
    w_wr_commit = 1'b0;
    w_rd_setup  = 1'b0;
    w_rd_issue  = 1'b0;
    w_rd_done   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start_write) begin
          if (w_n_clamp == '0) w_wr_commit = 1'b1;
          else                 w_state_nxt = WRITE;
        end else if (start_read) begin
          if (w_found) begin
            w_rd_setup  = 1'b1;
            w_state_nxt = READ;
          end else begin
            w_rd_done   = 1'b1;
          end
        end
      end
      WRITE: begin
        if (wr_valid) begin
          w_wr_acc = 1'b1;
          if ((int'(r_beat) + 1) >= lines_of(r_wr_n)) begin
            w_wr_commit = 1'b1;
            w_state_nxt = IDLE;
          end
        end
      end
      READ: begin
        if (!r_rd_vld || read_new_line) begin
          if (r_iss_more) begin
            w_rd_issue  = 1'b1;
          end else if (r_rd_vld) begin
            w_rd_done   = 1'b1;
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Write side: latch frame header, count beats, commit slot metadata on completion
  always_ff @(posedge clk or posedge reset_N) begin
    if (reset_N) begin
      r_wr_slot <= '0;
      r_count   <= '0;
      r_wr_fn   <= '0;
      r_wr_n    <= '0;
      r_beat    <= '0;
      for (int i = 0; i < HIST_DEPTH; i++) begin
        r_meta_n[i]  <= '0;
        r_meta_fn[i] <= '0;
      end
    end else begin
      if (r_state == IDLE && start_write) begin
        r_wr_fn <= frame_num;
        r_wr_n  <= w_n_clamp;
        r_beat  <= '0;
      end else if (w_wr_acc) begin
        r_beat  <= r_beat + LINE_W'(1);
      end
      if (w_wr_commit) begin
        r_meta_n[r_wr_slot]  <= w_commit_n;
        r_meta_fn[r_wr_slot] <= w_commit_fn;
        r_wr_slot <= (int'(r_wr_slot) == HIST_DEPTH - 1) ? '0 : r_wr_slot + SLOT_W'(1);
        if (int'(r_count) != HIST_DEPTH) r_count <= r_count + HIST_W'(1);
      end
    end
  end

  // Read issue pointer: walks lines of the current frame, then jumps to the next non-empty frame
  always_ff @(posedge clk or posedge reset_N) begin
    if (reset_N) begin
      r_frames   <= '0;
      r_iss_hist <= '0;
      r_iss_line <= '0;
      r_iss_more <= 1'b0;
    end else if (w_rd_setup) begin
      r_frames   <= w_f;
      r_iss_hist <= w_found_k;
      r_iss_line <= '0;
      r_iss_more <= 1'b1;
    end else if (w_rd_issue) begin
      if ((int'(r_iss_line) + 1) < lines_of(w_iss_n)) begin
        r_iss_line <= r_iss_line + LINE_W'(1);
      end else begin
        r_iss_line <= '0;
        r_iss_hist <= w_found_k;
        r_iss_more <= w_found;
      end
    end
  end

  // Output registers: line sideband follows the bank read, done strobes are one-cycle pulses
  always_ff @(posedge clk or posedge reset_N) begin
    if (reset_N) begin
      r_rd_vld   <= 1'b0;
      r_lane_vld <= '0;
      r_rd_fn    <= '0;
      r_rd_hist  <= '0;
      r_done_wr  <= 1'b0;
      r_done_rd  <= 1'b0;
    end else begin
      r_done_wr <= w_wr_commit;
      r_done_rd <= w_rd_done;
      if (w_rd_issue) begin
        r_rd_vld   <= 1'b1;
        r_lane_vld <= w_rd_mask;
        r_rd_fn    <= r_meta_fn[w_iss_slot];
        r_rd_hist  <= r_iss_hist;
      end else if (w_rd_done) begin
        r_rd_vld   <= 1'b0;
      end
    end
  end

  oflow_mem_history_bank #(
    .DATA_W (DATA_W),
    .LANES  (LANES),
    .DEPTH  (HIST_DEPTH * LPF),
    .ADDR_W (ADDR_W)
  ) u_bank (
    .i_clk     (clk),
    .i_rst     (reset_N),
    .i_wr_en   (w_bank_we),
    .i_wr_addr (w_wr_addr),
    .i_wr_dat  (wr_data),
    .i_rd_en   (w_rd_issue),
    .i_rd_addr (w_rd_addr),
    .o_rd_dat  (rd_data)
  );

  assign wr_ready      = (r_state == WRITE);
  assign rd_valid      = r_rd_vld;
  assign rd_lane_valid = r_lane_vld;
  assign rd_frame_num  = r_rd_fn;
  assign rd_hist_idx   = r_rd_hist;
  assign done_write    = r_done_wr;
  assign done_read     = r_done_rd;
  assign counter_of_history_frame_to_interface = r_count;

endmodule

// File: tb/tb_oflow_mem_history_buffer.sv
// Directed bench for the frame-history buffer at default parameters.
// Inputs change and outputs are sampled on the falling clock edge.
// Each scenario task carries its own hand-derived expectations.
module tb_oflow_mem_history_buffer;

  localparam int DATA_W      = 64;
  localparam int LANES       = 2;
  localparam int MAX_BBOX    = 32;
  localparam int HIST_DEPTH  = 5;
  localparam int FRAME_NUM_W = 8;

  logic         clk = 1'b0;
  logic         reset_N;
  logic         start_write, start_read;
  logic [7:0]   frame_num;
  logic [5:0]   num_of_bbox_in_frame;
  logic [2:0]   num_of_history_frames;
  logic         wr_valid, wr_ready;
  logic [127:0] wr_data;
  logic         read_new_line, rd_valid;
  logic [127:0] rd_data;
  logic [1:0]   rd_lane_valid;
  logic [7:0]   rd_frame_num;
  logic [2:0]   rd_hist_idx;
  logic         done_write, done_read;
  logic [2:0]   counter_of_history_frame_to_interface;

  int n_checks  = 0;
  int n_errors  = 0;
  int exp_count = 0;
  int ex_fn [5];
  int ex_n  [5];
  int ex_h  [5];

  always #5 clk = ~clk;

  oflow_mem_history_buffer #(
    .DATA_W(DATA_W), .LANES(LANES), .MAX_BBOX(MAX_BBOX),
    .HIST_DEPTH(HIST_DEPTH), .FRAME_NUM_W(FRAME_NUM_W)
  ) dut (
    .clk(clk), .reset_N(reset_N), .start_write(start_write), .start_read(start_read),
    .frame_num(frame_num), .num_of_bbox_in_frame(num_of_bbox_in_frame),
    .num_of_history_frames(num_of_history_frames), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data), .read_new_line(read_new_line), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_lane_valid(rd_lane_valid), .rd_frame_num(rd_frame_num), .rd_hist_idx(rd_hist_idx),
    .done_write(done_write), .done_read(done_read),
    .counter_of_history_frame_to_interface(counter_of_history_frame_to_interface)
  );

  function automatic logic [63:0] rec(input int fn, input int r);
    return {16'hC0DE, 16'(fn), 32'(r)};
  endfunction

  task automatic apply_reset();
    reset_N = 1'b1;
    start_write = 0; start_read = 0; wr_valid = 0; read_new_line = 0;
    repeat (2) @(negedge clk);
    reset_N = 1'b0;
    exp_count = 0;
    @(negedge clk);
  endtask

  // Write one frame; n above MAX_BBOX is expected to be clamped
  task automatic write_frame(input int fn, input int n, input bit also_read);
    int nc, beats;
    nc    = (n > MAX_BBOX) ? MAX_BBOX : n;
    beats = (nc + LANES - 1) / LANES;
    frame_num = 8'(fn);
    num_of_bbox_in_frame = 6'(n);
    start_write = 1'b1;
    start_read  = also_read;
    @(negedge clk);
    start_write = 1'b0;
    for (int b = 0; b < beats; b++) begin
      n_checks++;
      if (wr_ready !== 1'b1) begin
        n_errors++;
        $display("FAIL wr_ready f%0d beat%0d: got %b want 1", fn, b, wr_ready);
      end
      wr_valid = 1'b1;
      wr_data  = {rec(fn, 2*b+1), rec(fn, 2*b)};
      @(negedge clk);
    end
    wr_valid   = 1'b0;
    start_read = 1'b0;
    if (exp_count < HIST_DEPTH) exp_count++;
    n_checks++;
    if ({done_write, wr_ready, counter_of_history_frame_to_interface} !== {1'b1, 1'b0, 3'(exp_count)}) begin
      n_errors++;
      $display("FAIL write_done f%0d: got dw=%b rdy=%b cnt=%0d want dw=1 rdy=0 cnt=%0d",
               fn, done_write, wr_ready, counter_of_history_frame_to_interface, exp_count);
    end
    if (also_read) begin
      n_checks++;
      if ({done_read, rd_valid} !== 2'b00) begin
        n_errors++;
        $display("FAIL read_dropped f%0d: got dr=%b rv=%b want 0 0", fn, done_read, rd_valid);
      end
    end
    @(negedge clk);
    n_checks++;
    if (done_write !== 1'b0) begin
      n_errors++;
      $display("FAIL done_write_pulse f%0d: got %b want 0", fn, done_write);
    end
  endtask

  // Replay history and compare against ex_fn/ex_n/ex_h (nf non-empty frames, newest first)
  task automatic read_frames(input int depth, input int nf, input bit hold, input string tag);
    int total, lines;
    logic [1:0] m;
    total = 0;
    for (int f = 0; f < nf; f++) total += (ex_n[f] + 1) / 2;
    num_of_history_frames = 3'(depth);
    start_read = 1'b1;
    @(negedge clk);
    start_read = 1'b0;
    if (total == 0) begin
      n_checks++;
      if ({done_read, rd_valid} !== 2'b10) begin
        n_errors++;
        $display("FAIL %s empty_done: got dr=%b rv=%b want 1 0", tag, done_read, rd_valid);
      end
    end else begin
      n_checks++;
      if ({done_read, rd_valid} !== 2'b00) begin
        n_errors++;
        $display("FAIL %s latency: got dr=%b rv=%b want 0 0", tag, done_read, rd_valid);
      end
      @(negedge clk);
      for (int f = 0; f < nf; f++) begin
        lines = (ex_n[f] + 1) / 2;
        for (int ln = 0; ln < lines; ln++) begin
          m = {(2*ln+1 < ex_n[f]), (2*ln < ex_n[f])};
          n_checks++;
          if ({rd_valid, done_read, rd_frame_num, rd_hist_idx, rd_lane_valid} !==
              {1'b1, 1'b0, 8'(ex_fn[f]), 3'(ex_h[f]), m}) begin
            n_errors++;
            $display("FAIL %s line f%0d l%0d: got v=%b d=%b fn=%0d h=%0d m=%b want v=1 d=0 fn=%0d h=%0d m=%b",
                     tag, f, ln, rd_valid, done_read, rd_frame_num, rd_hist_idx, rd_lane_valid,
                     ex_fn[f], ex_h[f], m);
          end
          for (int l = 0; l < LANES; l++) begin
            if (m[l]) begin
              n_checks++;
              if (rd_data[l*64 +: 64] !== rec(ex_fn[f], 2*ln+l)) begin
                n_errors++;
                $display("FAIL %s data f%0d l%0d lane%0d: got %h want %h",
                         tag, f, ln, l, rd_data[l*64 +: 64], rec(ex_fn[f], 2*ln+l));
              end
            end
          end
          if (!hold) begin
            @(negedge clk);
            n_checks++;
            if ({rd_valid, rd_frame_num, rd_lane_valid, rd_data[63:0]} !==
                {1'b1, 8'(ex_fn[f]), m, rec(ex_fn[f], 2*ln)}) begin
              n_errors++;
              $display("FAIL %s stall f%0d l%0d: got v=%b fn=%0d m=%b d=%h", tag, f, ln,
                       rd_valid, rd_frame_num, rd_lane_valid, rd_data[63:0]);
            end
          end
          read_new_line = 1'b1;
          @(negedge clk);
          if (!hold) read_new_line = 1'b0;
        end
      end
      read_new_line = 1'b0;
      n_checks++;
      if ({done_read, rd_valid} !== 2'b10) begin
        n_errors++;
        $display("FAIL %s final_done: got dr=%b rv=%b want 1 0", tag, done_read, rd_valid);
      end
    end
    @(negedge clk);
    n_checks++;
    if ({done_read, rd_valid} !== 2'b00) begin
      n_errors++;
      $display("FAIL %s done_pulse: got dr=%b rv=%b want 0 0", tag, done_read, rd_valid);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if ({wr_ready, rd_valid, rd_data, rd_lane_valid, rd_frame_num, rd_hist_idx, done_write,
         done_read, counter_of_history_frame_to_interface} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: got rdy=%b rv=%b data=%h m=%b fn=%0d cnt=%0d want all 0",
               wr_ready, rd_valid, rd_data, rd_lane_valid, rd_frame_num,
               counter_of_history_frame_to_interface);
    end
    reset_N = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({wr_ready, rd_valid, done_write, done_read, counter_of_history_frame_to_interface} !== '0) begin
      n_errors++;
      $display("FAIL reset_release: got rdy=%b rv=%b dw=%b dr=%b cnt=%0d want all 0",
               wr_ready, rd_valid, done_write, done_read, counter_of_history_frame_to_interface);
    end
  endtask

  task automatic test_basic();
    write_frame(0, 5, 1'b0);
    write_frame(1, 5, 1'b0);
    write_frame(2, 5, 1'b0);
    ex_fn = '{2, 1, 0, 0, 0}; ex_n = '{5, 5, 0, 0, 0}; ex_h = '{0, 1, 0, 0, 0};
    read_frames(2, 2, 1'b0, "basic");
  endtask

  task automatic test_wrap();
    write_frame(3, 3, 1'b0);
    write_frame(4, 4, 1'b0);
    write_frame(5, 1, 1'b0);
    write_frame(6, 2, 1'b0);
    ex_fn = '{6, 5, 4, 3, 2}; ex_n = '{2, 1, 4, 3, 5}; ex_h = '{0, 1, 2, 3, 4};
    read_frames(5, 5, 1'b1, "wrap");
  endtask

  task automatic test_zero_frame();
    write_frame(7, 0, 1'b0);
    ex_fn = '{6, 5, 0, 0, 0}; ex_n = '{2, 1, 0, 0, 0}; ex_h = '{1, 2, 0, 0, 0};
    read_frames(3, 2, 1'b0, "zero_skip");
  endtask

  task automatic test_depth_clamp();
    apply_reset();
    write_frame(10, 3, 1'b0);
    write_frame(11, 4, 1'b0);
    ex_fn = '{11, 10, 0, 0, 0}; ex_n = '{4, 3, 0, 0, 0}; ex_h = '{0, 1, 0, 0, 0};
    read_frames(4, 2, 1'b0, "depth_clamp");
    apply_reset();
    read_frames(3, 0, 1'b0, "no_frames");
  endtask

  task automatic test_collision();
    apply_reset();
    write_frame(20, 2, 1'b1);
    ex_fn = '{20, 0, 0, 0, 0}; ex_n = '{2, 0, 0, 0, 0}; ex_h = '{0, 0, 0, 0, 0};
    read_frames(1, 1, 1'b1, "collision");
  endtask

  task automatic test_reset_mid_write();
    frame_num = 8'd30;
    num_of_bbox_in_frame = 6'd6;
    start_write = 1'b1;
    @(negedge clk);
    start_write = 1'b0;
    wr_valid = 1'b1;
    wr_data  = {rec(30, 1), rec(30, 0)};
    @(negedge clk);
    wr_data  = {rec(30, 3), rec(30, 2)};
    reset_N  = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({wr_ready, rd_valid, rd_data, rd_lane_valid, rd_frame_num, rd_hist_idx, done_write,
         done_read, counter_of_history_frame_to_interface} !== '0) begin
      n_errors++;
      $display("FAIL midwrite_reset: got rdy=%b rv=%b dw=%b dr=%b cnt=%0d want all 0",
               wr_ready, rd_valid, done_write, done_read, counter_of_history_frame_to_interface);
    end
    reset_N  = 1'b0;
    wr_valid = 1'b0;
    exp_count = 0;
    @(negedge clk);
    n_checks++;
    if ({wr_ready, done_write, counter_of_history_frame_to_interface} !== '0) begin
      n_errors++;
      $display("FAIL midwrite_after: got rdy=%b dw=%b cnt=%0d want 0 0 0",
               wr_ready, done_write, counter_of_history_frame_to_interface);
    end
    read_frames(5, 0, 1'b0, "midwrite_read");
  endtask

  task automatic test_bbox_clamp();
    write_frame(40, 40, 1'b0);
    ex_fn = '{40, 0, 0, 0, 0}; ex_n = '{32, 0, 0, 0, 0}; ex_h = '{0, 0, 0, 0, 0};
    read_frames(1, 1, 1'b1, "bbox_clamp");
  endtask

  initial begin
    reset_N = 1'b0;
    start_write = 0; start_read = 0; wr_valid = 0; read_new_line = 0;
    frame_num = '0; num_of_bbox_in_frame = '0; num_of_history_frames = '0; wr_data = '0;
    #2 reset_N = 1'b1;
    test_reset();
    test_basic();
    test_wrap();
    test_zero_frame();
    test_depth_clamp();
    test_collision();
    test_reset_mid_write();
    test_bbox_clamp();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/oflow_mem_history_buffer.md
# oflow_mem_history_buffer

Parametrised multi-lane frame-history buffer. It stores the bounding-box records of the last `HIST_DEPTH` completed frames in a circular slot array and replays them line-by-line to the similarity-metric stage, newest frame first. Write and read phases are sequenced by an internal FSM with valid/ready handshakes. It replaces the fixed two-port, externally addressed memory wrapper in the core datapath.

## Interface
Parameters:
- `DATA_W`, 64, width of one bbox record
- `LANES`, 2, records moved per line (write beat / read line)
- `MAX_BBOX`, 32, max bboxes per frame
- `HIST_DEPTH`, 5, frame slots kept
- `FRAME_NUM_W`, 8, frame serial number width

Ports (`BBOX_W = $clog2(MAX_BBOX+1)`, `HIST_W = $clog2(HIST_DEPTH+1)`):
- `clk` in 1: single clock, rising edge
- `reset_N` in 1: asynchronous, active-high reset (asserted = 1)
- `start_write` in 1: begin storing one frame (sampled in IDLE only)
- `start_read` in 1: begin replaying history (sampled in IDLE only)
- `frame_num` in FRAME_NUM_W: serial number of the frame being written
- `num_of_bbox_in_frame` in BBOX_W: record count of the frame being written
- `num_of_history_frames` in HIST_W: frames to replay (fallback depth)
- `wr_valid` in 1 / `wr_ready` out 1: write-beat handshake
- `wr_data` in LANES*DATA_W: lane l at bits [l*DATA_W +: DATA_W]
- `read_new_line` in 1: consumer accepts the current read line
- `rd_valid` out 1: `rd_data` holds a valid line
- `rd_data` out LANES*DATA_W: read line
- `rd_lane_valid` out LANES: per-lane valid mask, partial on a frame's last line
- `rd_frame_num` out FRAME_NUM_W: serial number of the frame being replayed
- `rd_hist_idx` out HIST_W: 0 = newest frame being replayed
- `done_write`, `done_read` out 1: one-cycle completion pulses
- `counter_of_history_frame_to_interface` out HIST_W: completed frames stored (0..HIST_DEPTH)

## Operation
- FSM states: IDLE, WRITE, READ.
- IDLE → WRITE on `start_write`. Latch `frame_num` and n = min(`num_of_bbox_in_frame`, MAX_BBOX). Clear beat counter.
- WRITE: `wr_ready`=1. Each accepted beat b writes lane l to record b*LANES+l of slot `wr_slot`. Lanes with index ≥ n are dropped. Beats needed = ceil(n/LANES).
- After the last beat, or immediately when n=0:
  - store n and frame_num as slot metadata
  - `wr_slot` ← (wr_slot+1) mod HIST_DEPTH
  - stored count saturating-increments at HIST_DEPTH
  - pulse `done_write`, return to IDLE
- IDLE → READ on `start_read`. F = min(`num_of_history_frames`, stored count). If F=0, pulse `done_read` and return to IDLE.
- READ: slots are visited from `wr_slot`-1 down to `wr_slot`-F, wrapping mod HIST_DEPTH. Lines of slots with n=0 are skipped.
  - A line is presented with `rd_valid`=1 and held until `read_new_line`.
  - `read_new_line` while `rd_valid`=0 is ignored.
  - After the last line is accepted: `rd_valid`→0, pulse `done_read`, return to IDLE.
- Only completed frames are replayed. The frame being written is never visible.
- `start_write` and `start_read` together in IDLE: write wins, read is dropped (not queued). Any `start_*` outside IDLE is ignored.
- Reset (any state, mid-operation included): FSM → IDLE, `wr_slot`=0, stored count=0, all outputs 0. Array contents are undefined but unreachable.

## Timing
- Reset value of every output is 0, including `wr_ready`, `rd_data` and `rd_lane_valid`.
- `wr_ready` is decoded from the registered state. It is high from the cycle after `start_write` until the last beat is accepted.
- `done_write` is high the cycle after the last accepted beat, or the cycle after `start_write` when n=0.
- Read latency: the first `rd_valid` comes 2 cycles after `start_read` (1 cycle for the F/slot compute, 1 cycle for the registered array read).
- Each later line is valid 1 cycle after `read_new_line`. `rd_valid` stays high across the gap, with `rd_data` updating on that edge.
- Sustained rate is 1 line/cycle when `read_new_line` is held high.
- `done_read` is high in the cycle after the last `read_new_line`, which is the same cycle `rd_valid` falls.
- `counter_of_history_frame_to_interface` updates in the same cycle as `done_write`.

## Structure
- Package `oflow_mem_history_pkg` holds:
  - default parameter values
  - state enum `hist_state_e` {IDLE, WRITE, READ}
  - width helpers: BBOX_W, HIST_W, LINES_PER_FRAME = ceil(MAX_BBOX/LANES), ADDR_W
- Sub-module `oflow_mem_history_bank` is the storage array:
  - HIST_DEPTH*LINES_PER_FRAME lines × LANES*DATA_W
  - one write port with per-lane write enable
  - one registered read port
  - address = slot*LINES_PER_FRAME + line
- The top level holds the FSM, counters, slot metadata registers and output registers.

## Test plan
- Write 3 frames with n=5, LANES=2 (3 beats each; the third beat has lane 1 dropped). Then read with `num_of_history_frames`=2 → 6 lines. The frame-2 data comes first. Each frame's third line has `rd_lane_valid`=01. `done_read` goes high after the 6th accept.
- Write 7 frames (0..6) with HIST_DEPTH=5 → counter saturates at 5. Read with depth 5 → frames 6,5,4,3,2 in order (slot wrap covered).
- n=0 frame: `done_write` the cycle after `start_write` with `wr_ready` never high. A later read skips that frame with no lines.
- Request depth 4 with only 2 frames stored → only 2 frames replayed. Read with 0 frames stored → `done_read` 1 cycle after `start_read`, `rd_valid` stays 0.
- `start_write` and `start_read` in the same cycle → only a write runs. `start_read` during WRITE is ignored. `read_new_line` held high gives 1 line/cycle.
- Assert reset during the 2nd beat of a write → all outputs 0 and counter 0. A following read gives `done_read` with no lines.
